// File: rtl/exc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// exc_sequencer_pkg
//   Shared definitions for the exception/interrupt entry-return sequencer:
//   sequencer state encoding, default handler / reset addresses, the width
//   of the post-redirect drain counter, the Cause.ExcCode values the
//   sequencer produces or passes through, and the committed-PC helper used
//   for delay-slot victims.
// ---------------------------------------------------------------------------
package exc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2,
    ST_DRAIN  = 2'd3
  } exc_state_e;

  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_3000;

  // Drain lengths 1..7 fit in three bits.
  localparam int unsigned DRAIN_W = 3;

  // Cause.ExcCode values (bits [6:2] of Cause).
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // An instruction in a branch delay slot is restarted from its branch,
  // which sits one word earlier. Arithmetic wraps modulo 2^32.
  function automatic logic [31:0] commit_pc(input logic [31:0] pc,
                                            input logic        bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_drain_timer.sv
// ---------------------------------------------------------------------------
// exc_drain_timer
//   Down-counter that times the quiet period after a redirect.
//   Ports:
//     Clock       in   system clock, rising edge
//     Reset       in   asynchronous active-high reset (count -> 0)
//     load        in   load load_value on the next edge
//     load_value  in   number of cycles to count
//     done        out  high during the last counted cycle (count == 1)
//   After a load of N the counter spends N cycles non-zero; done marks the
//   N-th of them, so the caller leaves its wait state on that edge.
// ---------------------------------------------------------------------------
module exc_drain_timer
  import exc_sequencer_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load,
  input  logic [DRAIN_W-1:0] load_value,
  output logic               done
);

  logic [DRAIN_W-1:0] count;

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - DRAIN_W'(1);
    end
  end

  assign done = (count == DRAIN_W'(1));

endmodule

// File: rtl/exc_sequencer.sv
// ---------------------------------------------------------------------------
// exc_sequencer
//   Sequences exception/interrupt entry and ERET return for a MIPS-style
//   pipeline. A taken interrupt or M-stage exception produces one ENTER
//   cycle (EXL set, Cause/EPC data, flush, redirect to the handler); a taken
//   ERET produces one RETURN cycle (EXL clear, flush, redirect to EPC).
//   Either is followed by DRAIN_CYCLES cycles in which new requests are
//   ignored, giving the refetched pipeline time to settle.
//
//   Parameters:
//     HANDLER_ADDR  handler entry address
//     RESET_PC      reset value of the last-committed-PC tracker
//     DRAIN_CYCLES  quiet cycles after each redirect, legal range 1..7
//   Ports:
//     Clock, Reset        clock (rising edge), async active-high reset
//     IntReq              level interrupt request from CP0 status logic
//     MExc, MExcCode      M-stage exception valid and its code
//     MEret               M-stage ERET
//     MValid, MPC, MBD    M-stage holds a real instruction, its PC, BD flag
//     EPC                 current EPC register value
//     ExlSet, ExlClr      one-cycle strobes to CP0
//     ExcCode, VictimPC,  Cause.ExcCode, EPC value and Cause.BD written
//     BD                    with ExlSet
//     Flush, Redirect,    pipeline kill, fetch redirect and its target
//     RedirectPC
//     Busy                sequencer not idle
//   Every output is a flop; nothing passes combinationally from an input.
// ---------------------------------------------------------------------------
module exc_sequencer
  import exc_sequencer_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IntReq,
  input  logic        MExc,
  input  logic [6:2]  MExcCode,
  input  logic        MEret,
  input  logic        MValid,
  input  logic [31:0] MPC,
  input  logic        MBD,
  input  logic [31:0] EPC,
  output logic        ExlSet,
  output logic        ExlClr,
  output logic [6:2]  ExcCode,
  output logic [31:0] VictimPC,
  output logic        BD,
  output logic        Flush,
  output logic        Redirect,
  output logic [31:0] RedirectPC,
  output logic        Busy
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  exc_state_e  state;
  exc_state_e  state_nxt;
  logic [31:0] last_pc;
  logic        drain_load;
  logic        drain_done;

  // Values the output flops take on the coming edge.
  logic        exl_set_nxt;
  logic        exl_clr_nxt;
  logic [6:2]  exc_code_nxt;
  logic [31:0] victim_pc_nxt;
  logic        bd_nxt;
  logic        flush_nxt;
  logic        redirect_nxt;
  logic [31:0] redirect_pc_nxt;

  exc_drain_timer u_drain_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (drain_load),
    .load_value (DRAIN_LOAD),
    .done       (drain_done)
  );

  // Last committed PC: used as the victim when an interrupt arrives while the
  // M stage holds a bubble, so EPC points at the next instruction to run.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_pc <= RESET_PC;
    end else if (MValid) begin
      last_pc <= commit_pc(MPC, MBD);
    end
  end

  // Next state and next output values. Outputs are decided on the edge that
  // enters a state, so ENTER/RETURN strobes appear in that state's cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt       = state;
    drain_load      = 1'b0;
    exl_set_nxt     = 1'b0;
    exl_clr_nxt     = 1'b0;
    exc_code_nxt    = '0;
    victim_pc_nxt   = '0;
    bd_nxt          = 1'b0;
    flush_nxt       = 1'b0;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = '0;

    unique case (state)
      ST_IDLE: begin
        // Priority: interrupt, then exception, then ERET; losers are dropped.
        if (IntReq || (MExc && MValid)) begin
          state_nxt       = ST_ENTER;
          exl_set_nxt     = 1'b1;
          flush_nxt       = 1'b1;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = HANDLER_ADDR;
          exc_code_nxt    = IntReq ? EXC_INT : MExcCode;
          if (MValid) begin
            victim_pc_nxt = commit_pc(MPC, MBD);
            bd_nxt        = MBD;
          end else begin
            victim_pc_nxt = last_pc + 32'd4;
          end
        end else if (MEret && MValid) begin
          state_nxt       = ST_RETURN;
          exl_clr_nxt     = 1'b1;
          flush_nxt       = 1'b1;
          redirect_nxt    = 1'b1;
          redirect_pc_nxt = EPC;
        end
      end
      ST_ENTER, ST_RETURN: begin
        state_nxt  = ST_DRAIN;
        drain_load = 1'b1;
      end
      ST_DRAIN: begin
        if (drain_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears the outputs asynchronously, so
  // a reset landing in ENTER or RETURN cuts the strobe within the cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      ExlSet     <= 1'b0;
      ExlClr     <= 1'b0;
      ExcCode    <= '0;
      VictimPC   <= '0;
      BD         <= 1'b0;
      Flush      <= 1'b0;
      Redirect   <= 1'b0;
      RedirectPC <= '0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ExlSet     <= exl_set_nxt;
      ExlClr     <= exl_clr_nxt;
      ExcCode    <= exc_code_nxt;
      VictimPC   <= victim_pc_nxt;
      BD         <= bd_nxt;
      Flush      <= flush_nxt;
      Redirect   <= redirect_nxt;
      RedirectPC <= redirect_pc_nxt;
      Busy       <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exc_sequencer
//   Self-checking bench for exc_sequencer: directed scenarios for reset,
//   entry, delay-slot victims, priority, ERET with ignored requests, bubble
//   victims, PC wrap and reset during ENTER, followed by a randomized run
//   against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_exc_sequencer;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam int          DRAIN   = 3;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        IntReq, MExc, MEret, MValid, MBD;
  logic [6:2]  MExcCode;
  logic [31:0] MPC, EPC;
  logic        ExlSet, ExlClr, BD, Flush, Redirect, Busy;
  logic [6:2]  ExcCode;
  logic [31:0] VictimPC, RedirectPC;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        exl_set;
    logic        exl_clr;
    logic        flush;
    logic        redirect;
    logic        busy;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] victim;
    logic [31:0] rpc;
  } obs_t;

  exc_sequencer #(
    .HANDLER_ADDR (HANDLER),
    .RESET_PC     (RST_PC),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .IntReq     (IntReq),
    .MExc       (MExc),
    .MExcCode   (MExcCode),
    .MEret      (MEret),
    .MValid     (MValid),
    .MPC        (MPC),
    .MBD        (MBD),
    .EPC        (EPC),
    .ExlSet     (ExlSet),
    .ExlClr     (ExlClr),
    .ExcCode    (ExcCode),
    .VictimPC   (VictimPC),
    .BD         (BD),
    .Flush      (Flush),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---- observation and expectation builders ----
  function automatic obs_t observe();
    obs_t o;
    o.exl_set  = ExlSet;
    o.exl_clr  = ExlClr;
    o.flush    = Flush;
    o.redirect = Redirect;
    o.busy     = Busy;
    o.bd       = BD;
    o.code     = ExcCode;
    o.victim   = VictimPC;
    o.rpc      = RedirectPC;
    return o;
  endfunction

  function automatic obs_t exp_idle();
    obs_t o = '0;
    return o;
  endfunction

  function automatic obs_t exp_drain();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t exp_enter(input logic [4:0] code, input logic [31:0] victim,
                                     input logic bd);
    obs_t o = '0;
    o.exl_set  = 1'b1;
    o.flush    = 1'b1;
    o.redirect = 1'b1;
    o.busy     = 1'b1;
    o.bd       = bd;
    o.code     = code;
    o.victim   = victim;
    o.rpc      = HANDLER;
    return o;
  endfunction

  function automatic obs_t exp_return(input logic [31:0] rpc);
    obs_t o = '0;
    o.exl_clr  = 1'b1;
    o.flush    = 1'b1;
    o.redirect = 1'b1;
    o.busy     = 1'b1;
    o.rpc      = rpc;
    return o;
  endfunction

  task automatic clear_inputs();
    IntReq   = 1'b0;
    MExc     = 1'b0;
    MExcCode = '0;
    MEret    = 1'b0;
    MValid   = 1'b0;
    MPC      = '0;
    MBD      = 1'b0;
  endtask

  task automatic wait_idle(input string who);
    int n = 0;
    while (Busy !== 1'b0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: Busy=%b, required 0 within 20 cycles", who, Busy);
    end
  endtask

  // ---- directed scenarios ----
  task automatic test_reset();
    obs_t got;
    clear_inputs();
    EPC    = 32'h0000_3040;
    IntReq = 1'b1;
    MValid = 1'b1;
    MPC    = 32'h0000_1234;
    repeat (2) @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_idle()) begin
      errors++; $display("FAIL reset_hold: got %h required %h", got, exp_idle());
    end
    clear_inputs();
    Reset = 1'b0;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_idle()) begin
      errors++; $display("FAIL reset_release: got %h required %h", got, exp_idle());
    end
  endtask

  task automatic test_interrupt();
    obs_t got;
    IntReq = 1'b1; MValid = 1'b1; MPC = 32'h0000_3010; MBD = 1'b0;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd0, 32'h0000_3010, 1'b0)) begin
      errors++;
      $display("FAIL int_enter: got %h required %h", got, exp_enter(5'd0, 32'h0000_3010, 1'b0));
    end
    clear_inputs();
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge Clock);
      got = observe(); checks++;
      if (got !== exp_drain()) begin
        errors++; $display("FAIL int_drain%0d: got %h required %h", i, got, exp_drain());
      end
    end
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_idle()) begin
      errors++; $display("FAIL int_back_idle: got %h required %h", got, exp_idle());
    end
  endtask

  task automatic test_exception_bd();
    obs_t got;
    MExc = 1'b1; MExcCode = 5'd12; MValid = 1'b1; MPC = 32'h0000_3024; MBD = 1'b1;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd12, 32'h0000_3020, 1'b1)) begin
      errors++;
      $display("FAIL exc_bd_enter: got %h required %h", got, exp_enter(5'd12, 32'h0000_3020, 1'b1));
    end
    clear_inputs();
    wait_idle("exc_bd");
  endtask

  task automatic test_priority();
    obs_t got;
    logic saw_clr = 1'b0;
    IntReq = 1'b1; MExc = 1'b1; MExcCode = 5'd10; MEret = 1'b1;
    MValid = 1'b1; MPC = 32'h0000_3050; MBD = 1'b0;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd0, 32'h0000_3050, 1'b0)) begin
      errors++;
      $display("FAIL prio_enter: got %h required %h", got, exp_enter(5'd0, 32'h0000_3050, 1'b0));
    end
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      saw_clr = saw_clr | ExlClr;
    end
    checks++;
    if (saw_clr !== 1'b0) begin
      errors++; $display("FAIL prio_no_exlclr: ExlClr seen=%b, required 0", saw_clr);
    end
    wait_idle("prio");
  endtask

  task automatic test_eret_drain();
    obs_t got;
    EPC = 32'h0000_3040; MEret = 1'b1; MValid = 1'b1; MPC = 32'h0000_3064;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_return(32'h0000_3040)) begin
      errors++; $display("FAIL eret_return: got %h required %h", got, exp_return(32'h0000_3040));
    end
    // Exception held through RETURN and all of DRAIN must be ignored.
    clear_inputs();
    MExc = 1'b1; MExcCode = 5'd4; MValid = 1'b1; MPC = 32'h0000_3068;
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge Clock);
      got = observe(); checks++;
      if (got !== exp_drain()) begin
        errors++; $display("FAIL eret_drain%0d: got %h required %h", i, got, exp_drain());
      end
    end
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_idle()) begin
      errors++; $display("FAIL eret_ignored: got %h required %h", got, exp_idle());
    end
    clear_inputs();
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_idle()) begin
      errors++; $display("FAIL eret_not_queued: got %h required %h", got, exp_idle());
    end
  endtask

  task automatic test_lastpc();
    obs_t got;
    MValid = 1'b1; MPC = 32'h0000_3008; MBD = 1'b0;
    @(negedge Clock);
    clear_inputs();
    IntReq = 1'b1;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd0, 32'h0000_300C, 1'b0)) begin
      errors++;
      $display("FAIL lastpc_victim: got %h required %h", got, exp_enter(5'd0, 32'h0000_300C, 1'b0));
    end
    clear_inputs();
    wait_idle("lastpc");
  endtask

  task automatic test_wrap();
    obs_t got;
    MExc = 1'b1; MExcCode = 5'd5; MValid = 1'b1; MPC = 32'h0000_0000; MBD = 1'b1;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd5, 32'hFFFF_FFFC, 1'b1)) begin
      errors++;
      $display("FAIL wrap_minus4: got %h required %h", got, exp_enter(5'd5, 32'hFFFF_FFFC, 1'b1));
    end
    clear_inputs();
    wait_idle("wrap1");
    // Last committed PC is now FFFFFFFC; the bubble victim wraps to 0.
    IntReq = 1'b1;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd0, 32'h0000_0000, 1'b0)) begin
      errors++;
      $display("FAIL wrap_plus4: got %h required %h", got, exp_enter(5'd0, 32'h0000_0000, 1'b0));
    end
    clear_inputs();
    wait_idle("wrap2");
  endtask

  task automatic test_reset_in_enter();
    obs_t got;
    IntReq = 1'b1; MValid = 1'b1; MPC = 32'h0000_3100;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd0, 32'h0000_3100, 1'b0)) begin
      errors++;
      $display("FAIL rst_enter_pre: got %h required %h", got, exp_enter(5'd0, 32'h0000_3100, 1'b0));
    end
    #1 Reset = 1'b1;
    #1;
    got = observe(); checks++;
    if (got !== exp_idle()) begin
      errors++; $display("FAIL rst_enter_abort: got %h required %h", got, exp_idle());
    end
    clear_inputs();
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < DRAIN + 1; i++) begin
      @(negedge Clock);
      got = observe(); checks++;
      if (got !== exp_idle()) begin
        errors++; $display("FAIL rst_enter_after%0d: got %h required %h", i, got, exp_idle());
      end
    end
    IntReq = 1'b1;
    @(negedge Clock);
    got = observe(); checks++;
    if (got !== exp_enter(5'd0, RST_PC + 32'd4, 1'b0)) begin
      errors++;
      $display("FAIL rst_lastpc: got %h required %h", got, exp_enter(5'd0, RST_PC + 32'd4, 1'b0));
    end
    clear_inputs();
    wait_idle("rst_enter");
  endtask

  // ---- randomized run against a transaction-level model ----
  // The model sees a request only while it expects the sequencer to be idle
  // (Busy low); a taken request schedules its event cycle followed by DRAIN
  // busy-only cycles. Every edge with a valid M-stage instruction updates
  // the committed PC.
  task automatic test_random();
    obs_t        cur, nxt, got, drain_rec;
    obs_t        pending[$];
    logic [31:0] model_last_pc;
    logic [31:0] vic;

    clear_inputs();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    cur           = exp_idle();
    model_last_pc = RST_PC;
    drain_rec     = exp_drain();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      IntReq   = ($urandom_range(0, 9) == 0);
      MExc     = ($urandom_range(0, 7) == 0);
      MEret    = ($urandom_range(0, 7) == 0);
      MValid   = ($urandom_range(0, 3) != 0);
      MBD      = ($urandom_range(0, 3) == 0);
      MExcCode = 5'($urandom_range(0, 31));
      MPC      = ($urandom_range(0, 15) == 0) ? (32'($urandom_range(0, 2)) << 2)
                                              : ($urandom() & 32'hFFFF_FFFC);
      EPC      = $urandom();

      if (pending.size() > 0) begin
        nxt = pending.pop_front();
      end else if (cur.busy) begin
        nxt = exp_idle();
      end else if (IntReq || (MExc && MValid)) begin
        if (MValid) vic = MBD ? (MPC - 32'd4) : MPC;
        else        vic = model_last_pc + 32'd4;
        nxt = exp_enter(IntReq ? 5'd0 : MExcCode, vic, MValid ? MBD : 1'b0);
        for (int k = 0; k < DRAIN; k++) pending.push_back(drain_rec);
      end else if (MEret && MValid) begin
        nxt = exp_return(EPC);
        for (int k = 0; k < DRAIN; k++) pending.push_back(drain_rec);
      end else begin
        nxt = exp_idle();
      end
      if (MValid) model_last_pc = MBD ? (MPC - 32'd4) : MPC;

      @(negedge Clock);
      got = observe(); checks++;
      if (got !== nxt) begin
        errors++; $display("FAIL random_cycle%0d: got %h required %h", cyc, got, nxt);
      end
      cur = nxt;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_priority();
    test_eret_drain();
    test_lastpc();
    test_wrap();
    test_reset_in_enter();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 Parameter HANDLER_ADDR, 32'h00004180, exception/interrupt handler entry address.
REQ-002 Parameter RESET_PC, 32'h00003000, initial value of the last-committed-PC tracker.
REQ-003 Parameter DRAIN_CYCLES, 3, cycles new requests are ignored after any redirect; legal range 1..7.
REQ-004 Clock  in  1  single system clock, rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 IntReq  in  1  interrupt request from the coprocessor-0 status logic, level.
REQ-007 MExc, MExcCode[6:2], MEret  in  1/5/1  M-stage exception valid, its code, M-stage ERET.
REQ-008 MValid, MPC[31:0], MBD  in  1/32/1  M-stage holds a real instruction, its PC, delay-slot flag.
REQ-009 EPC  in  32  current EPC register value from coprocessor 0.
REQ-010 ExlSet, ExlClr  out  1/1  one-cycle strobes to coprocessor 0.
REQ-011 ExcCode[6:2], VictimPC[31:0], BD  out  5/32/1  values written into Cause/EPC on ExlSet.
REQ-012 Flush, Redirect, RedirectPC[31:0], Busy  out  1/1/32/1  pipeline kill, fetch redirect, target, sequencer not idle.

Function
REQ-013 States SHALL be IDLE, ENTER, RETURN, DRAIN; all outputs SHALL be registered.
REQ-014 LastPC SHALL load MPC on every edge where MValid=1 and MBD=0, and MPC-4 where MValid=1 and MBD=1.
REQ-015 In IDLE, request priority SHALL be IntReq > MExc (MValid=1) > MEret (MValid=1); lower ones SHALL be dropped that cycle.
REQ-016 IDLE with a taken IntReq or MExc SHALL go to ENTER next edge; with a taken MEret, to RETURN.
REQ-017 ENTER SHALL last exactly one cycle with ExlSet=1, Flush=1, Redirect=1, RedirectPC=HANDLER_ADDR.
REQ-018 In ENTER, ExcCode SHALL be 5'd0 for interrupt, else the latched MExcCode.
REQ-019 In ENTER, VictimPC SHALL be MPC (MBD=0) or MPC-4 (MBD=1) if MValid was 1 at capture, else LastPC+4; BD SHALL be the captured MBD (0 when MValid=0).
REQ-020 RETURN SHALL last one cycle with ExlClr=1, Flush=1, Redirect=1, RedirectPC=EPC sampled in that cycle.
REQ-021 ENTER and RETURN SHALL go to DRAIN; DRAIN SHALL count DRAIN_CYCLES cycles then return to IDLE.
REQ-022 All requests arriving in ENTER, RETURN or DRAIN SHALL be ignored, not queued; a still-asserted IntReq SHALL be retaken in IDLE.
REQ-023 Busy SHALL be 1 in every state except IDLE.
REQ-024 Outside ENTER, ExlSet/ExcCode/VictimPC/BD SHALL be 0; outside ENTER/RETURN, Flush/Redirect/RedirectPC SHALL be 0.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; MPC-4 at 0 SHALL wrap to 32'hFFFFFFFC.

Reset
REQ-026 Reset SHALL force state IDLE, drain counter 0, LastPC=RESET_PC and all outputs 0, asynchronously.
REQ-027 Reset asserted in ENTER or RETURN SHALL abort the strobe in the same cycle; no ExlSet/ExlClr SHALL follow deassertion.

Structure
REQ-028 State encoding, HANDLER_ADDR and RESET_PC defaults and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) SHALL live in a shared package.
REQ-029 The drain counter SHALL be a sub-module exc_drain_timer (load, count-down, done).
REQ-030 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-031 IntReq=1 at IDLE, MValid=1, MPC=32'h3010, MBD=0 -> next cycle ExlSet=1, ExcCode=0, VictimPC=32'h3010, RedirectPC=32'h4180, Busy for 4 cycles.
REQ-032 MExc=1, MExcCode=12, MPC=32'h3024, MBD=1 -> ENTER with ExcCode=12, VictimPC=32'h3020, BD=1.
REQ-033 IntReq=1, MExc=1, MEret=1 same cycle -> ExcCode=0, ExlClr never asserted.
REQ-034 MEret=1 with EPC=32'h3040 -> one cycle ExlClr=1, Redirect=1, RedirectPC=32'h3040; MExc pulsed during DRAIN produces no ExlSet.
REQ-035 Last valid MPC=32'h3008, then MValid=0 with IntReq=1 -> VictimPC=32'h300C, BD=0.
REQ-036 Reset asserted during ENTER -> all outputs 0 immediately, IDLE after release, LastPC=32'h3000.
